// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Misaligned or beyond the end of instruction memory.
    function automatic logic addr_bad(input logic [XLEN-1:0] addr, input logic [XLEN:0] limit);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            stall_i;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] instruction_adress;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instruction;
    logic            fetch_valid;
    logic            fetch_fault;

    modport master (
        input  stall_i, redirect_valid, redirect_target, instruction,
        output instruction_adress, fetch_pc, fetch_instruction, fetch_valid, fetch_fault
    );

    modport slave (
        output stall_i, redirect_valid, redirect_target, instruction,
        input  instruction_adress, fetch_pc, fetch_instruction, fetch_valid, fetch_fault
    );

endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry pc+instruction holding register with load, clear and valid flag.
module fetch_hold_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_entry,
    output logic         o_valid
);

    fetch_entry_t r_entry;
    logic         r_valid;

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_entry <= i_entry;
            r_valid <= 1'b1;
        end
    end

    assign o_entry = r_entry;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, stall hold, redirect bubble and sticky range/alignment fault.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS = 256
)(
    input  logic clk,
    input  logic rst,
    fetch_unit_if.master bus
);

    localparam logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(IMEM_WORDS * INSTR_BYTES);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_rsp_pc, w_rsp_pc_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic            r_fault, w_fault_nxt;
    logic            r_end, w_end_nxt;
    logic [XLEN:0]   w_pc_inc;

    logic            w_hold_load, w_hold_clear, w_hold_valid;
    fetch_entry_t    w_hold_d, w_hold_q;

    logic            w_fetch_valid;
    logic [XLEN-1:0] w_fetch_pc, w_fetch_instr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_rsp_pc    <= RESET_PC;
            r_rsp_valid <= 1'b0;
            r_fault     <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_rsp_pc    <= w_rsp_pc_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_fault     <= w_fault_nxt;
            r_end       <= w_end_nxt;
        end
    end

    // r_end: the last legal word is already in flight, so the next advance faults instead of issuing past the end.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_rsp_pc_nxt    = r_rsp_pc;
        w_rsp_valid_nxt = r_rsp_valid;
        w_fault_nxt     = r_fault;
        w_end_nxt       = r_end;
        w_hold_load     = 1'b0;
        w_hold_clear    = 1'b0;
        w_pc_inc        = {1'b0, r_pc} + (XLEN+1)'(INSTR_BYTES);

        unique case (r_state)
            RUN, STALL: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt        = bus.redirect_target;
                    w_rsp_valid_nxt = 1'b0;
                    w_hold_clear    = 1'b1;
                    w_end_nxt       = 1'b0;
                    if (addr_bad(bus.redirect_target, IMEM_BYTES)) begin
                        w_state_nxt = FAULT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if (r_state == RUN && bus.stall_i && w_fetch_valid) begin
                    w_hold_load = 1'b1;
                    w_state_nxt = STALL;
                end else if (r_state == STALL && bus.stall_i) begin
                    w_state_nxt = STALL;
                end else if (r_end) begin
                    w_state_nxt     = FAULT;
                    w_fault_nxt     = 1'b1;
                    w_rsp_valid_nxt = 1'b0;
                    w_hold_clear    = 1'b1;
                end else begin
                    w_rsp_pc_nxt    = r_pc;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RUN;
                    if (w_pc_inc >= IMEM_BYTES) begin
                        w_end_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_inc[XLEN-1:0];
                    end
                end
            end
            default: begin
                w_state_nxt = FAULT;
            end
        endcase
    end

    // Presentation mux toward decode.
    always_comb begin
        w_fetch_valid = 1'b0;
        w_fetch_pc    = r_rsp_pc;
        w_fetch_instr = NOP_INSTR;
        unique case (r_state)
            STALL: begin
                w_fetch_valid = w_hold_valid;
                w_fetch_pc    = w_hold_q.pc;
                w_fetch_instr = w_hold_q.instr;
            end
            RUN: begin
                w_fetch_valid = r_rsp_valid;
                if (r_rsp_valid) begin
                    w_fetch_instr = bus.instruction;
                end
            end
            default: begin
                w_fetch_valid = 1'b0;
            end
        endcase
    end

    assign w_hold_d = '{pc: r_rsp_pc, instr: bus.instruction};

    fetch_hold_buffer u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_entry (w_hold_d),
        .o_entry (w_hold_q),
        .o_valid (w_hold_valid)
    );

    assign bus.instruction_adress = r_pc;
    assign bus.fetch_pc           = w_fetch_pc;
    assign bus.fetch_instruction  = w_fetch_instr;
    assign bus.fetch_valid        = w_fetch_valid;
    assign bus.fetch_fault        = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level stream model.
module tb_fetch_unit;

    localparam int unsigned WORDS = 256;
    localparam logic [31:0] LIMIT = 32'(WORDS * 4);
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC), .IMEM_WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [WORDS];

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) bus.instruction <= mem[bus.instruction_adress[9:2]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: the presented item, the next word to fetch, and the sticky fault.
    logic        m_valid, m_fault, m_reset_seen;
    logic [31:0] m_pc, m_next, m_fault_addr;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b0; m_fault = 1'b0; m_pc = RPC; m_next = RPC;
            m_fault_addr = '0; m_reset_seen = 1'b1;
        end else if (!m_fault) begin
            m_reset_seen = 1'b0;
            if (bus.redirect_valid) begin
                m_valid = 1'b0;
                if (bus.redirect_target[1:0] != 2'b00 || bus.redirect_target >= LIMIT) begin
                    m_fault = 1'b1; m_fault_addr = bus.redirect_target;
                end else begin
                    m_next = bus.redirect_target;
                end
            end else if (!(m_valid && bus.stall_i)) begin
                if (m_next >= LIMIT) begin
                    m_fault = 1'b1; m_valid = 1'b0; m_fault_addr = LIMIT - 32'd4;
                end else begin
                    m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
                end
            end
        end else begin
            m_reset_seen = 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_fault", 32'(bus.fetch_fault), 32'(m_fault));
            chk("cyc_valid", 32'(bus.fetch_valid), 32'(m_valid && !m_fault));
            chk("cyc_addr", bus.instruction_adress,
                m_fault ? m_fault_addr : (m_next >= LIMIT ? LIMIT - 32'd4 : m_next));
            if (m_valid && !m_fault) begin
                chk("cyc_pc", bus.fetch_pc, m_pc);
                chk("cyc_instr", bus.fetch_instruction, mem[m_pc[9:2]]);
            end else begin
                chk("cyc_nop", bus.fetch_instruction, NOP);
            end
            if (m_reset_seen) chk("cyc_rst_pc", bus.fetch_pc, RPC);
        end
    end

    // Drive one cycle of inputs, then land just after the following falling edge.
    task automatic tick(input logic st, input logic rv, input logic [31:0] tg);
        bus.stall_i = st;
        bus.redirect_valid = rv;
        bus.redirect_target = tg;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] adr, input logic f);
        chk({name, "_valid"}, 32'(bus.fetch_valid), 32'(v));
        if (v) chk({name, "_pc"}, bus.fetch_pc, pc);
        chk({name, "_instr"}, bus.fetch_instruction, ins);
        chk({name, "_addr"}, bus.instruction_adress, adr);
        chk({name, "_fault"}, 32'(bus.fetch_fault), 32'(f));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st, rv, r;
        logic [31:0] tg;
        int k;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        rst = 1'b0;
        bus.stall_i = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        @(negedge clk); #1;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        expect_out("reset", 1'b0, RPC, NOP, RPC, 1'b0);
        chk("reset_pc", bus.fetch_pc, RPC);
        rst = 1'b1;

        tick(1'b0, 1'b0, 32'h0);
        expect_out("first", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("seq4", 1'b1, 32'h4, mem[1], 32'h8, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("seq8", 1'b1, 32'h8, mem[2], 32'hC, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            expect_out("stall", 1'b1, 32'h8, mem[2], 32'hC, 1'b0);
        end
        tick(1'b0, 1'b0, 32'h0);
        expect_out("unstall", 1'b1, 32'hC, mem[3], 32'h10, 1'b0);

        tick(1'b1, 1'b1, 32'h40);
        expect_out("redir_bubble", 1'b0, 32'h0, NOP, 32'h40, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("redir_tgt", 1'b1, 32'h40, mem[16], 32'h44, 1'b0);

        tick(1'b0, 1'b1, 32'h3F8);
        expect_out("end_bubble", 1'b0, 32'h0, NOP, 32'h3F8, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("end_3f8", 1'b1, 32'h3F8, mem[254], 32'h3FC, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("end_3fc", 1'b1, 32'h3FC, mem[255], 32'h3FC, 1'b0);
        tick(1'b0, 1'b0, 32'h0);
        expect_out("end_fault", 1'b0, 32'h0, NOP, 32'h3FC, 1'b1);

        do_reset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        expect_out("pre_rst_stall", 1'b1, 32'h0, mem[0], 32'h4, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b0, 32'h0);
        expect_out("rst_in_stall", 1'b0, RPC, NOP, RPC, 1'b0);
        chk("rst_in_stall_pc", bus.fetch_pc, RPC);
        rst = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        expect_out("post_rst", 1'b1, 32'h0, mem[0], 32'h4, 1'b0);

        tick(1'b0, 1'b1, 32'h42);
        expect_out("mis_fault", 1'b0, 32'h0, NOP, 32'h42, 1'b1);
        tick(1'b0, 1'b1, 32'h0);
        expect_out("mis_sticky", 1'b0, 32'h0, NOP, 32'h42, 1'b1);
        tick(1'b1, 1'b0, 32'h0);
        expect_out("mis_sticky2", 1'b0, 32'h0, NOP, 32'h42, 1'b1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 3) == 0);
            rst = !r;
            st = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 9) == 0);
            k = $urandom_range(0, 49);
            if (k == 0)      tg = {$urandom_range(0, 255) == 0 ? 30'h0 : 30'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (k == 1) tg = LIMIT + {28'($urandom_range(0, 4095)), 2'b00};
            else if (k < 12) tg = 32'h3E0 + 32'(4 * $urandom_range(0, 7));
            else             tg = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            tick(st, rv, tg);
        end
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Generates the word-aligned byte address each cycle and pairs the memory's registered, 1-cycle-latency read data with its PC.
- Presents {pc, instruction, valid} to decode.
- Handles decode back-pressure (stall) with a one-entry hold buffer, branch/jump redirects with a one-cycle bubble, and a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words; the legal byte range is 0 .. IMEM_WORDS*4-4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stall_i  in  1  decode cannot accept the presented instruction this cycle.
- redirect_valid  in  1  load a new PC (taken branch/jump).
- redirect_target  in  32  byte address for the redirect.
- instruction_adress  out  32  byte address to the instruction memory; equals pc_q.
- instruction  in  32  memory read data for the address issued in the previous cycle.
- fetch_pc  out  32  PC of the presented instruction.
- fetch_instruction  out  32  presented instruction; NOP 32'h0000_0013 when not valid.
- fetch_valid  out  1  presented instruction is valid.
- fetch_fault  out  1  sticky fetch fault.

Behaviour:
- State machine: RUN, STALL, FAULT. Internal registers:
  - pc_q: next address to issue.
  - rsp_pc_q / rsp_valid_q: describe the request now on `instruction`.
  - hold_instr_q / hold_pc_q: hold buffer.
- Reset (rst=0 at an edge), values take effect next cycle:
  - state=RUN, pc_q=RESET_PC, rsp_valid_q=0, fault=0, hold cleared.
  - Outputs: instruction_adress=RESET_PC, fetch_valid=0, fetch_pc=RESET_PC, fetch_instruction=NOP, fetch_fault=0.
  - Reset mid-stall or in FAULT behaves identically.
- Output mux (combinational):
  - STALL: hold_instr_q / hold_pc_q, fetch_valid=1.
  - RUN: instruction / rsp_pc_q, fetch_valid=rsp_valid_q; instruction forced to NOP when invalid.
  - FAULT: fetch_valid=0, NOP.
- RUN, no redirect, and (stall_i=0 or fetch_valid=0): rsp_pc_q<=pc_q, rsp_valid_q<=1, pc_q<=pc_q+4.
  - First valid instruction appears 2 cycles after reset release: cycle 1 issues the address, cycle 2 presents the data.
- RUN, stall_i=1, fetch_valid=1: capture instruction/rsp_pc_q into the hold buffer, state<=STALL, pc_q held.
  - While in STALL, memory keeps reading pc_q.
- STALL, stall_i=1: hold all state; outputs stable.
- STALL, stall_i=0: held entry is consumed this cycle. At the edge: rsp_pc_q<=pc_q, rsp_valid_q<=1, pc_q<=pc_q+4, state<=RUN. No bubble.
- Redirect has priority over stall in RUN and STALL: pc_q<=redirect_target, rsp_valid_q<=0, hold discarded, state<=RUN.
  - Next cycle: fetch_valid=0 (bubble).
  - Following cycle: target instruction valid.
  - The instruction presented in the redirect cycle is not consumed by fetch (decode discards it).
- Fault conditions:
  - redirect_target[1:0]!=0, or redirect_target >= IMEM_WORDS*4: state<=FAULT, fetch_fault<=1, pc_q<=redirect_target.
  - A sequential increment producing pc_q+4 >= IMEM_WORDS*4 enters FAULT instead; the last legal word is still delivered.
- FAULT: ignores stall_i and redirect_valid; only reset exits.
- The 32-bit PC add wraps modulo 2^32, but the range check fires first.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {RUN, STALL, FAULT}.
  - XLEN = 32.
  - INSTR_BYTES = 4.
- One natural sub-module: fetch_hold_buffer, a one-entry pc+instruction register with load/clear and valid flag.
- The PC/state logic stays in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0, memory word0=32'h00500093 → fetch_valid=0 for one cycle, then pc 0 / 32'h00500093, then pc 4, 8 on consecutive cycles.
- stall_i=1 for 3 cycles while presenting pc 8 → fetch_pc=8 and fetch_instruction constant throughout, instruction_adress stays 12; after release, pc 12 valid on the next cycle, no bubble.
- redirect_valid=1, target 32'h40 while stall_i=1 → next cycle fetch_valid=0 and instruction_adress=32'h40; following cycle fetch_pc=32'h40 valid.
- redirect target 32'h42 → fetch_fault=1 next cycle and stays 1, fetch_valid=0, further redirects to 32'h0 ignored until rst=0.
- Sequential fetch from 32'h3F8 with IMEM_WORDS=256 → pc 3F8 and 3FC delivered valid, then fetch_fault=1, fetch_valid=0.
- rst=0 asserted during STALL → next cycle fetch_valid=0, fetch_pc=RESET_PC, fetch_instruction=NOP, hold cleared.
